debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Parametrised multi-channel successor to the single-button debouncer: N independent mechanical inputs, each with a two-flop synchroniser, a programmable-length stability counter and symmetric press/release filtering.
- Emits a clean level plus one-cycle rise/fall pulses per channel.
- Contains an internal sample prescaler, so it runs directly from the board clock instead of a separate 5 kHz clock.
- Sits between the board push-buttons/switches and the control FSMs.

Parameters:
- N, 4, number of independent channels (1..32).
- STABLE_CNT, 8, consecutive agreeing samples required to change the debounced state (2..255).
- CLK_DIV, 10000, clk_in cycles per sample tick (1 = sample every cycle).
- REPEAT_DELAY, 2500, sample ticks a level must stay high before the first repeat pulse (used only with the optional feature).
- REPEAT_RATE, 500, sample ticks between subsequent repeat pulses (used only with the optional feature).

Ports:
- clk_in  input  1  system clock, all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- button  input  N  raw asynchronous inputs, bit i = channel i.
- state  output  N  debounced level per channel.
- rise  output  N  one-cycle pulse when state[i] goes 0->1.
- fall  output  N  one-cycle pulse when state[i] goes 1->0.
- tick  output  1  one-cycle sample strobe (debug/observability).
- rep  output  N  auto-repeat pulse (optional feature; constant 0 otherwise).

Behaviour:
- Reset: rst=1 asynchronously clears the synchroniser flops, the per-channel counters, the prescaler, the repeat counters and all outputs (state=0, rise=0, fall=0, tick=0, rep=0). The block resumes on the first clk_in edge after rst deasserts. A bounce in progress at reset is discarded.
- Synchroniser: two-flop synchroniser per channel, sync2[i]. Only sync2 feeds the filter.
- Prescaler:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - tick=1 for exactly the one cycle in which the counter equals CLK_DIV-1.
  - With CLK_DIV=1, tick is constantly 1 after reset.
  - Counter width is clog2(CLK_DIV), minimum 1 bit.
- Per-channel filter, evaluated only on cycles with tick=1:
  - If sync2[i]==state[i]: cnt[i] <= 0.
  - If sync2[i]!=state[i] and cnt[i]<STABLE_CNT-1: cnt[i] <= cnt[i]+1.
  - If sync2[i]!=state[i] and cnt[i]==STABLE_CNT-1: state[i] <= ~state[i], cnt[i] <= 0.
  - A single agreeing sample restarts the count, so press and release are filtered identically (unlike the old block, which released instantly).
  - cnt width is clog2(STABLE_CNT). The counter never exceeds STABLE_CNT-1, so no wrap is possible.
  - Cycles without tick hold cnt and state.
- Latency: with CLK_DIV=1, an input change set up before edge 0 appears on sync2 after edge 1. Mismatching samples occur at edges 2..(STABLE_CNT+1), so state changes after edge STABLE_CNT+1. For STABLE_CNT=8 that is 10 edges.
- Edges:
  - rise[i] and fall[i] are registered and asserted in the same cycle that state[i] shows its new value, for exactly one clk_in cycle.
  - rise[i] and fall[i] are never both 1.
  - Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-operation: outputs return to 0 within the reset, with no rise/fall pulse. A button held through reset is re-qualified from count 0, so rise fires STABLE_CNT ticks after release of rst (plus synchroniser delay).

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined:
  - Each channel has a repeat counter that runs only while state[i]=1.
  - rep[i] pulses for one cycle on the tick on which the counter reaches REPEAT_DELAY after rise[i].
  - After that, rep[i] pulses every REPEAT_RATE ticks.
  - The counter clears when state[i]=0 or rst=1.
  - rep never coincides with rise.
- Not defined: no repeat counters are synthesised and rep is tied to 0.

Test Plan:
- Reset values: assert rst mid-simulation with button=4'hF held -> state=0, rise=0, fall=0 and tick=0 immediately, without waiting for a clock edge.
- Clean press: N=4, STABLE_CNT=8, CLK_DIV=1; button[0] 0->1 before edge 0 -> state[0]=1 and rise[0]=1 after edge 9, rise[0]=0 after edge 10, channels 1-3 unchanged.
- Bounce rejection: CLK_DIV=1; button[1] high for 7 cycles, low 1 cycle, then high steady -> no transition during the glitch; state[1] rises 8 samples after the final high is synchronised; exactly one rise pulse.
- Symmetric release and prescaler: CLK_DIV=4; release button[2] after it is stable high -> fall[2] occurs 8 ticks (about 32 cycles + 2) later; tick period measured at 4 cycles.
- Simultaneous channels: button 4'b0000 -> 4'b1010 in one cycle -> rise=4'b1010 in a single cycle, state=4'b1010.
- Repeat (DEBOUNCE_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, CLK_DIV=1): hold button[3] -> rep[3] pulses 5 ticks after rise, then every 2 ticks. Release -> rep stops. Without the macro -> rep stays 0.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: N-channel push-button debouncer with two-flop synchronisers, an
// internal sample prescaler and symmetric press/release filtering. Defining
// DEBOUNCE_REPEAT_EN adds per-channel auto-repeat pulses on rep; otherwise rep is 0.
module debounce_bank #(
  parameter int N            = 4,
  parameter int STABLE_CNT   = 8,
  parameter int CLK_DIV      = 10000,
  parameter int REPEAT_DELAY = 2500,
  parameter int REPEAT_RATE  = 500
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic [N-1:0] button,
  output logic [N-1:0] state,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         tick,
  output logic [N-1:0] rep
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  if (N < 1 || N > 32) begin : g_bad_n
    $error("debounce_bank: N must be in 1..32");
  end
  if (STABLE_CNT < 2 || STABLE_CNT > 255) begin : g_bad_stable
    $error("debounce_bank: STABLE_CNT must be in 2..255");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("debounce_bank: CLK_DIV must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("debounce_bank: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  logic [N-1:0]       sync1_p0;
  logic [N-1:0]       sync2_p1;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_nxt;
  logic [CNT_W-1:0]   cnt [N];
  logic [N-1:0]       mism;
  logic [N-1:0]       flip;

  // Stage p0/p1: two-flop synchroniser on the raw inputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
    end else begin
      sync1_p0 <= button;
      sync2_p1 <= sync1_p0;
    end
  end

  // Prescaler: tick is registered so it reads 1 exactly while div_cnt == CLK_DIV-1
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      tick    <= (div_nxt == DIV_LAST);
    end
  end

  // Stage p2: stability filter, advanced only on sample ticks
  always_comb begin
    mism = sync2_p1 ^ state;
    flip = '0;
    for (int i = 0; i < N; i++) begin
      flip[i] = tick & mism[i] & (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state <= state ^ flip;
      rise  <= flip & ~state;
      fall  <= flip & state;
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          if (!mism[i] || flip[i]) begin
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = REPEAT_DELAY + REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_WRAP  = RPT_W'(RPT_MAX);

  logic [RPT_W-1:0] rpt_cnt [N];
  logic [RPT_W-1:0] rpt_nxt [N];
  logic [N-1:0]     rpt_hit;

  // Counter folds back to REPEAT_DELAY after each rate period, so it stays bounded
  always_comb begin
    rpt_hit = '0;
    for (int i = 0; i < N; i++) begin
      rpt_nxt[i] = rpt_cnt[i] + 1'b1;
      rpt_hit[i] = tick & state[i] & ~flip[i] &
                   ((rpt_nxt[i] == RPT_FIRST) | (rpt_nxt[i] == RPT_WRAP));
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rep <= '0;
      for (int i = 0; i < N; i++) begin
        rpt_cnt[i] <= '0;
      end
    end else begin
      rep <= rpt_hit;
      for (int i = 0; i < N; i++) begin
        if (!state[i] || flip[i]) begin
          rpt_cnt[i] <= '0;
        end else if (tick) begin
          rpt_cnt[i] <= (rpt_nxt[i] == RPT_WRAP) ? RPT_FIRST : rpt_nxt[i];
        end
      end
    end
  end
`else
  assign rep = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Testbench for debounce_bank: two instances (CLK_DIV=1 and CLK_DIV=4) checked every
// cycle against a behavioural model, plus directed vector table and corner sequences.
module tb_debounce_bank;

  localparam int N  = 4;
  localparam int SC = 8;
  localparam int RD = 5;
  localparam int RR = 2;
  localparam int DIVS [2] = '{1, 4};
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] button = '0;

  logic [N-1:0] st_a, ri_a, fa_a, rp_a;
  logic [N-1:0] st_b, ri_b, fa_b, rp_b;
  logic         tk_a, tk_b;

  always #5 clk = ~clk;

  debounce_bank #(.N(N), .STABLE_CNT(SC), .CLK_DIV(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_a (
    .clk_in(clk), .rst(rst), .button(button),
    .state(st_a), .rise(ri_a), .fall(fa_a), .tick(tk_a), .rep(rp_a)
  );

  debounce_bank #(.N(N), .STABLE_CNT(SC), .CLK_DIV(4), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_b (
    .clk_in(clk), .rst(rst), .button(button),
    .state(st_b), .rise(ri_b), .fall(fa_b), .tick(tk_b), .rep(rp_b)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state, one slot per instance
  int           k_m    [2];
  bit           tk_m   [2];
  logic [N-1:0] s1_m   [2];
  logic [N-1:0] s2_m   [2];
  logic [N-1:0] st_m   [2];
  logic [N-1:0] ri_m   [2];
  logic [N-1:0] fa_m   [2];
  logic [N-1:0] rp_m   [2];
  int           run_m  [2][N];
  int           held_m [2][N];

  typedef struct {
    logic [N-1:0] btn;
    int           hold;
    logic [N-1:0] exp_st;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      k_m[d] = 0; tk_m[d] = 1'b0;
      s1_m[d] = '0; s2_m[d] = '0; st_m[d] = '0;
      ri_m[d] = '0; fa_m[d] = '0; rp_m[d] = '0;
      for (int i = 0; i < N; i++) begin
        run_m[d][i] = 0;
        held_m[d][i] = 0;
      end
    end
  endtask

  // One clock edge of the model: a level flips after SC consecutive disagreeing samples
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] st;
      logic [N-1:0] s2;
      bit           t;
      st = st_m[d]; s2 = s2_m[d]; t = tk_m[d];
      ri_m[d] = '0; fa_m[d] = '0; rp_m[d] = '0;
      for (int i = 0; i < N; i++) begin
        if (t) begin
          if (s2[i] != st[i]) begin
            run_m[d][i]++;
            if (run_m[d][i] == SC) begin
              run_m[d][i] = 0;
              st_m[d][i] = ~st[i];
              if (st[i]) fa_m[d][i] = 1'b1;
              else ri_m[d][i] = 1'b1;
            end
          end else begin
            run_m[d][i] = 0;
          end
          if (st[i] && st_m[d][i]) begin
            held_m[d][i]++;
            if (REP_EN && (held_m[d][i] == RD ||
                (held_m[d][i] > RD && (held_m[d][i] - RD) % RR == 0)))
              rp_m[d][i] = 1'b1;
          end else begin
            held_m[d][i] = 0;
          end
        end
      end
      s2_m[d] = s1_m[d];
      s1_m[d] = button;
      k_m[d]++;
      tk_m[d] = (k_m[d] % DIVS[d]) == (DIVS[d] - 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    chk("a_outputs", 32'({st_a, ri_a, fa_a, rp_a, tk_a}),
        32'({st_m[0], ri_m[0], fa_m[0], rp_m[0], tk_m[0]}));
    chk("b_outputs", 32'({st_b, ri_b, fa_b, rp_b, tk_b}),
        32'({st_m[1], ri_m[1], fa_m[1], rp_m[1], tk_m[1]}));
  endtask

  initial begin
    vec_t vecs [8];
    int   rises;
    bit   early;
    int   t0, t1, n, reps;
    bit   found;

    model_reset();
    #1 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();

    // Clean press on channel 0
    button = 4'b0001;
    for (int e = 0; e <= 10; e++) begin
      step();
      if (e == 8) chk("press_state_before", 32'(st_a), 32'h0);
      if (e == 9) begin
        chk("press_state", 32'(st_a), 32'h1);
        chk("press_rise", 32'(ri_a), 32'h1);
      end
      if (e == 10) chk("press_rise_gone", 32'(ri_a), 32'h0);
    end

    // Vector table: hold a pattern for N cycles, then compare debounced state
    vecs[0] = '{4'b0000, 14, 4'b0000};
    vecs[1] = '{4'b1010,  5, 4'b0000};
    vecs[2] = '{4'b1010,  9, 4'b1010};
    vecs[3] = '{4'b0110,  3, 4'b1010};
    vecs[4] = '{4'b0110, 12, 4'b0110};
    vecs[5] = '{4'b1111, 12, 4'b1111};
    vecs[6] = '{4'b0000,  9, 4'b1111};
    vecs[7] = '{4'b0000,  1, 4'b0000};
    for (int v = 0; v < 8; v++) begin
      button = vecs[v].btn;
      repeat (vecs[v].hold) step();
      chk($sformatf("vec%0d_state", v), 32'(st_a), 32'(vecs[v].exp_st));
    end

    // Bounce rejection on channel 1: 7 high, 1 low, then steady high
    rises = 0; early = 1'b0;
    button = 4'b0010;
    for (int e = 0; e <= 30; e++) begin
      if (e == 7) button = 4'b0000;
      if (e == 8) button = 4'b0010;
      step();
      if (ri_a[1]) rises++;
      if (e < 17 && st_a[1]) early = 1'b1;
      if (e == 17) chk("bounce_state", 32'(st_a[1]), 32'h1);
    end
    chk("bounce_no_early", 32'(early), 32'h0);
    chk("bounce_rise_count", 32'(rises), 32'h1);
    button = 4'b0000;
    repeat (14) step();

    // Simultaneous channels
    button = 4'b1010;
    for (int e = 0; e <= 10; e++) begin
      step();
      if (e == 8) chk("simul_rise_early", 32'(ri_a), 32'h0);
      if (e == 9) begin
        chk("simul_rise", 32'(ri_a), 32'hA);
        chk("simul_state", 32'(st_a), 32'hA);
      end
      if (e == 10) chk("simul_rise_gone", 32'(ri_a), 32'h0);
    end
    button = 4'b0000;
    repeat (14) step();

    // Prescaler period and symmetric release on the CLK_DIV=4 instance
    button = 4'b0100;
    t0 = -1; t1 = -1;
    for (int e = 0; e < 60; e++) begin
      step();
      if (tk_b && t0 < 0) t0 = e;
      else if (tk_b && t1 < 0) t1 = e;
    end
    chk("b_tick_period", 32'(t1 - t0), 32'd4);
    chk("b_state_held", 32'(st_b[2]), 32'h1);
    button = 4'b0000;
    n = 0; found = 1'b0;
    while (!found && n < 60) begin
      step();
      n++;
      if (fa_b[2]) found = 1'b1;
    end
    checks++;
    if (!found || n < 31 || n > 34) begin
      errors++;
      $display("FAIL b_fall_latency: got %0d edges (seen=%0d) expected 31..34", n, found);
    end

    // Auto-repeat on channel 3
    reps = 0;
    button = 4'b1000;
    repeat (40) begin
      step();
      if (rp_a[3]) reps++;
    end
    chk("rep_count_held", 32'(reps), REP_EN ? 32'd13 : 32'd0);
    button = 4'b0000;
    repeat (12) step();
    reps = 0;
    repeat (20) begin
      step();
      if (rp_a[3]) reps++;
    end
    chk("rep_after_release", 32'(reps), 32'd0);

    // Asynchronous reset with all buttons held, then re-qualification
    button = 4'hF;
    repeat (20) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_state", 32'(st_a), 32'h0);
    chk("rst_rise", 32'(ri_a), 32'h0);
    chk("rst_fall", 32'(fa_a), 32'h0);
    chk("rst_tick", 32'(tk_a), 32'h0);
    chk("rst_rep", 32'(rp_a), 32'h0);
    chk("rst_b_state_tick", 32'({st_b, tk_b}), 32'h0);
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      step();
      if (e == 8) chk("requal_early", 32'(st_a), 32'h0);
      if (e == 9) chk("requal_rise", 32'(ri_a), 32'hF);
    end

    // Random stimulus: fast toggling, then slow toggling
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) button[i] = ~button[i];
      step();
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 79) == 0) button[i] = ~button[i];
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
